// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard / forwarding controller.
//   fwd_sel_t   : ALU operand source select (RF, write-back, EX/MEM)
//   stage_tag_t : per-stage decoded control tag carried alongside the pipeline
package hazard_pkg;

  localparam int unsigned FWD_SEL_W = 2;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Register addresses live beside the tag so the address width can stay a
  // module parameter of the users.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_to_reg;
    logic mem_access;
    logic pc_src;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

  // Side effects of an instruction leaving E only survive if its condition passed.
  function automatic stage_tag_t tag_leave_e(input stage_tag_t t, input logic cond_ok);
    stage_tag_t r;
    r            = t;
    r.reg_write  = t.reg_write  & cond_ok;
    r.mem_access = t.mem_access & cond_ok;
    r.pc_src     = t.pc_src     & cond_ok;
    return r;
  endfunction

endpackage

// File: rtl/hazard_fwd_mux.sv
// One EX operand forwarding path: compares the E source register against the
// M and W destinations and selects the operand (EX/MEM beats write-back).
// Ports:
//   ra                 : E source register address
//   m_fwd_en, m_rd     : M stage holds a valid register write to m_rd
//   w_fwd_en, w_rd     : W stage holds a valid register write to w_rd
//   rf_data/mem_data/wb_data : candidate operand values
//   sel_c, data_c      : combinational select and forwarded operand
module hazard_fwd_mux
  import hazard_pkg::*;
#(
  parameter int unsigned WIDTH  = 22,
  parameter int unsigned REG_AW = 4
) (
  input  logic [REG_AW-1:0] ra,
  input  logic              m_fwd_en,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              w_fwd_en,
  input  logic [REG_AW-1:0] w_rd,
  input  logic [WIDTH-1:0]  rf_data,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic [WIDTH-1:0]  wb_data,
  output fwd_sel_t          sel_c,
  output logic [WIDTH-1:0]  data_c
);

  // Source selection, youngest producer first.
  always_comb begin
    sel_c = FWD_RF;
    if (m_fwd_en && (m_rd == ra)) begin
      sel_c = FWD_MEM;
    end else if (w_fwd_en && (w_rd == ra)) begin
      sel_c = FWD_WB;
    end
  end

  // Operand mux.
  always_comb begin
    data_c = rf_data;
    case (sel_c)
      FWD_MEM: data_c = mem_data;
      FWD_WB:  data_c = wb_data;
      default: data_c = rf_data;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for a D/E/M/W pipeline. Tracks decoded
// register usage in its own E/M/W tag pipeline and produces stall, flush and
// operand-forwarding controls plus the forwarded EX operands.
// Optional feature macro: HZ_MEM_WAIT_EN (adds mem_ready, multi-cycle memory stall).
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   d_*                         : decoded fields of the instruction in D
//   e_cond_ok                   : condition result of the instruction in E
//   e_rd1, e_rd2                : register-file operands in ID/EX
//   m_alu_result, w_result      : forwarding sources from EX/MEM and write-back
//   mem_ready                   : data memory done (HZ_MEM_WAIT_EN only)
//   stall_f/d/e/m, flush_d/e    : pipeline register hold / clear controls
//   fwd_a_sel, fwd_b_sel        : operand source (00 RF, 01 WB, 10 MEM)
//   e_src_a, e_src_b            : forwarded ALU operands
//   w_rd, w_reg_write           : register-file write port control
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned WIDTH  = 22,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_ra1,
  input  logic [REG_AW-1:0] d_ra2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_reg_write,
  input  logic              d_mem_to_reg,
  input  logic              d_mem_access,
  input  logic              d_pc_src,
  input  logic              e_cond_ok,
  input  logic [WIDTH-1:0]  e_rd1,
  input  logic [WIDTH-1:0]  e_rd2,
  input  logic [WIDTH-1:0]  m_alu_result,
  input  logic [WIDTH-1:0]  w_result,
`ifdef HZ_MEM_WAIT_EN
  input  logic              mem_ready,
`endif
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [WIDTH-1:0]  e_src_a,
  output logic [WIDTH-1:0]  e_src_b,
  output logic [REG_AW-1:0] w_rd,
  output logic              w_reg_write
);

  stage_tag_t        e_tag_q, e_tag_d;
  stage_tag_t        m_tag_q, m_tag_d;
  stage_tag_t        w_tag_q, w_tag_d;
  logic [REG_AW-1:0] e_rd_q,  e_rd_d;
  logic [REG_AW-1:0] e_ra1_q, e_ra1_d;
  logic [REG_AW-1:0] e_ra2_q, e_ra2_d;
  logic [REG_AW-1:0] m_rd_q,  m_rd_d;
  logic [REG_AW-1:0] w_rd_q,  w_rd_d;

  stage_tag_t d_tag_c;
  logic       load_use_c;
  logic       branch_c;
  logic       mem_wait_c;
  logic       m_fwd_en_c;
  logic       w_fwd_en_c;
  fwd_sel_t   fwd_a_sel_c;
  fwd_sel_t   fwd_b_sel_c;

  always_comb begin
    d_tag_c            = TAG_BUBBLE;
    d_tag_c.valid      = d_valid;
    d_tag_c.reg_write  = d_reg_write;
    d_tag_c.mem_to_reg = d_mem_to_reg;
    d_tag_c.mem_access = d_mem_access;
    d_tag_c.pc_src     = d_pc_src;
  end

  // A cond-failed load never writes its destination, so it cannot cause load-use.
  assign load_use_c = e_tag_q.valid & e_tag_q.mem_to_reg & e_tag_q.reg_write & e_cond_ok
                    & d_valid & ((e_rd_q == d_ra1) | (e_rd_q == d_ra2));
  assign branch_c   = e_tag_q.valid & e_tag_q.pc_src & e_cond_ok;

`ifdef HZ_MEM_WAIT_EN
  assign mem_wait_c = m_tag_q.valid & m_tag_q.mem_access & ~mem_ready;
`else
  assign mem_wait_c = 1'b0;
`endif

  // Hazard priority: memory wait freezes everything (branch resolves on release),
  // then taken branch, then load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_wait_c) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (branch_c) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use_c) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Tag pipeline advance.
  always_comb begin
    e_tag_d = d_tag_c;
    e_rd_d  = d_rd;
    e_ra1_d = d_ra1;
    e_ra2_d = d_ra2;
    m_tag_d = tag_leave_e(e_tag_q, e_cond_ok);
    m_rd_d  = e_rd_q;
    w_tag_d = m_tag_q;
    w_rd_d  = m_rd_q;
    if (mem_wait_c) begin
      e_tag_d = e_tag_q;
      e_rd_d  = e_rd_q;
      e_ra1_d = e_ra1_q;
      e_ra2_d = e_ra2_q;
      m_tag_d = m_tag_q;
      m_rd_d  = m_rd_q;
      w_tag_d = TAG_BUBBLE;
    end else if (flush_e) begin
      e_tag_d = TAG_BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_tag_q <= TAG_BUBBLE;
      m_tag_q <= TAG_BUBBLE;
      w_tag_q <= TAG_BUBBLE;
      e_rd_q  <= '0;
      e_ra1_q <= '0;
      e_ra2_q <= '0;
      m_rd_q  <= '0;
      w_rd_q  <= '0;
    end else begin
      e_tag_q <= e_tag_d;
      m_tag_q <= m_tag_d;
      w_tag_q <= w_tag_d;
      e_rd_q  <= e_rd_d;
      e_ra1_q <= e_ra1_d;
      e_ra2_q <= e_ra2_d;
      m_rd_q  <= m_rd_d;
      w_rd_q  <= w_rd_d;
    end
  end

  assign m_fwd_en_c = m_tag_q.valid & m_tag_q.reg_write;
  assign w_fwd_en_c = w_tag_q.valid & w_tag_q.reg_write;

  hazard_fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_a (
    .ra       (e_ra1_q),
    .m_fwd_en (m_fwd_en_c),
    .m_rd     (m_rd_q),
    .w_fwd_en (w_fwd_en_c),
    .w_rd     (w_rd_q),
    .rf_data  (e_rd1),
    .mem_data (m_alu_result),
    .wb_data  (w_result),
    .sel_c    (fwd_a_sel_c),
    .data_c   (e_src_a)
  );

  hazard_fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_b (
    .ra       (e_ra2_q),
    .m_fwd_en (m_fwd_en_c),
    .m_rd     (m_rd_q),
    .w_fwd_en (w_fwd_en_c),
    .w_rd     (w_rd_q),
    .rf_data  (e_rd2),
    .mem_data (m_alu_result),
    .wb_data  (w_result),
    .sel_c    (fwd_b_sel_c),
    .data_c   (e_src_b)
  );

  assign fwd_a_sel   = fwd_a_sel_c;
  assign fwd_b_sel   = fwd_b_sel_c;
  assign w_rd        = w_rd_q;
  assign w_reg_write = w_fwd_en_c;

  // W-stage memory/branch flags have no consumer past write-back.
  logic unused_w_flags;
  assign unused_w_flags = ^{w_tag_q.mem_to_reg, w_tag_q.mem_access, w_tag_q.pc_src};

endmodule
